// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised pipeline register file with two asynchronous
// read ports, one write port, write-through bypass, an optional hard-wired
// zero register and a per-register busy scoreboard for the hazard unit.
module reg_file_sb #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 3,
    parameter int                ZERO_R0   = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    output logic [DATA_W-1:0] Bus1,
    output logic [DATA_W-1:0] Bus2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] WBus,
    input  logic              Alloc,
    input  logic [ADDR_W-1:0] AllocRd
);

    localparam int  DEPTH    = 1 << ADDR_W;
    localparam bit  HAS_ZERO = (ZERO_R0 != 0);

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic              wrOk;
    logic              allocOk;

    // Writes and allocations aimed at a hard-wired R0 are dropped here
    always_comb begin
        wrOk    = RegWr && !(HAS_ZERO && (Rd == '0));
        allocOk = Alloc && !(HAS_ZERO && (AllocRd == '0));
    end

    // Next scoreboard state: a write retires its producer, a new allocation
    // on the same index wins because it describes a younger producer
    always_comb begin
        busyNext = busy;
        if (RegWr) begin
            busyNext[Rd] = 1'b0;
        end
        if (allocOk) begin
            busyNext[AllocRd] = 1'b1;
        end
        if (HAS_ZERO) begin
            busyNext[0] = 1'b0;
        end
    end

    // Register array: reset loads every entry, otherwise commit the WB write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= RESET_VAL;
            end
        end else if (wrOk) begin
            rf[Rd] <= WBus;
        end
    end

    // Scoreboard register: cleared on reset, otherwise takes the merged update
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    // Read data with zero-register forcing and same-cycle write bypass
    function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] val;
        if (reset) begin
            val = '0;
        end else if (HAS_ZERO && (idx == '0)) begin
            val = '0;
        end else if (RegWr && (Rd == idx)) begin
            val = WBus;
        end else begin
            val = rf[idx];
        end
        return val;
    endfunction

    // Busy status: a write in this cycle already satisfies the consumer
    function automatic logic readBusy(input logic [ADDR_W-1:0] idx);
        logic val;
        if (reset) begin
            val = 1'b0;
        end else begin
            val = busy[idx] && !(RegWr && (Rd == idx));
        end
        return val;
    endfunction

    // Both read ports are purely combinational views of the same state
    always_comb begin
        Bus1  = readData(Rs1);
        Bus2  = readData(Rs2);
        Busy1 = readBusy(Rs1);
        Busy2 = readBusy(Rs2);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against a
// behavioural model, plus a wide/deep parameter variant without zero register.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic [2:0]  Rs1, Rs2, Rd, AllocRd;
    logic [15:0] Bus1, Bus2, WBus;
    logic        Busy1, Busy2, RegWr, Alloc;

    logic        bReset;
    logic [3:0]  bRs1, bRs2, bRd, bAllocRd;
    logic [31:0] bBus1, bBus2, bWBus;
    logic        bBusy1, bBusy2, bRegWr, bAlloc;

    int total = 0;
    int bad   = 0;

    logic [15:0] modelRf   [8];
    bit          modelBusy [8];

    reg_file_sb dut (
        .clk(clk), .reset(reset), .Rs1(Rs1), .Rs2(Rs2), .Bus1(Bus1), .Bus2(Bus2),
        .Busy1(Busy1), .Busy2(Busy2), .RegWr(RegWr), .Rd(Rd), .WBus(WBus),
        .Alloc(Alloc), .AllocRd(AllocRd)
    );

    reg_file_sb #(
        .DATA_W(32), .ADDR_W(4), .ZERO_R0(0), .RESET_VAL(32'hFFFF_FFFF)
    ) dutWide (
        .clk(clk), .reset(bReset), .Rs1(bRs1), .Rs2(bRs2), .Bus1(bBus1), .Bus2(bBus2),
        .Busy1(bBusy1), .Busy2(bBusy2), .RegWr(bRegWr), .Rd(bRd), .WBus(bWBus),
        .Alloc(bAlloc), .AllocRd(bAllocRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected read value from the architectural rules
    function automatic logic [15:0] expBus(input logic [2:0] idx);
        if (reset) return 16'h0;
        if (idx == 3'd0) return 16'h0;
        if (RegWr && Rd == idx) return WBus;
        return modelRf[idx];
    endfunction

    function automatic logic expBusy(input logic [2:0] idx);
        if (reset) return 1'b0;
        if (RegWr && Rd == idx) return 1'b0;
        return modelBusy[idx];
    endfunction

    // Drive one cycle of inputs at negedge and compare all outputs to the model
    task automatic applyStimulus(input logic rst, input logic wr, input logic [2:0] rd,
                                 input logic [15:0] wbus, input logic al, input logic [2:0] ard,
                                 input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clk);
        reset = rst; RegWr = wr; Rd = rd; WBus = wbus;
        Alloc = al; AllocRd = ard; Rs1 = r1; Rs2 = r2;
        #2;
        checkOutput("bus1", {16'h0, Bus1}, {16'h0, expBus(r1)});
        checkOutput("bus2", {16'h0, Bus2}, {16'h0, expBus(r2)});
        checkOutput("busy1", {31'h0, Busy1}, {31'h0, expBusy(r1)});
        checkOutput("busy2", {31'h0, Busy2}, {31'h0, expBusy(r2)});
    endtask

    // Advance past the rising edge and apply the same cycle to the model
    task automatic commit();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                modelRf[i]   = 16'h0;
                modelBusy[i] = 1'b0;
            end
        end else begin
            if (RegWr && Rd != 3'd0) modelRf[Rd] = WBus;
            if (RegWr) modelBusy[Rd] = 1'b0;
            if (Alloc && AllocRd != 3'd0) modelBusy[AllocRd] = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            modelRf[i] = 16'h0;
            modelBusy[i] = 1'b0;
        end
        bReset = 1'b1; bRegWr = 1'b0; bRd = '0; bWBus = '0;
        bAlloc = 1'b0; bAllocRd = '0; bRs1 = '0; bRs2 = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); commit();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); commit();

        // Reset after random traffic
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 3'($urandom_range(1, 7)), 16'($urandom), 1,
                          3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom));
            commit();
        end
        applyStimulus(1, 1, 3, 16'h7777, 1, 4, 3, 4);
        checkOutput("rst_bus_forced", {16'h0, Bus1}, 32'h0);
        commit();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
            checkOutput("rst_bus_idx", {16'h0, Bus1}, 32'h0);
            checkOutput("rst_busy_idx", {31'h0, Busy1}, 32'h0);
            commit();
        end

        // Write then read, with bypass on port 2
        applyStimulus(0, 1, 3, 16'hBEEF, 0, 0, 1, 3);
        checkOutput("bypass_beef", {16'h0, Bus2}, 32'hBEEF);
        commit();
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 3);
        checkOutput("read_beef", {16'h0, Bus1}, 32'hBEEF);
        commit();

        // Zero register
        applyStimulus(0, 1, 0, 16'h1234, 0, 0, 0, 0);
        checkOutput("r0_bypass", {16'h0, Bus1}, 32'h0);
        commit();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("r0_after", {16'h0, Bus1}, 32'h0);
        commit();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_busy", {31'h0, Busy1}, 32'h0);
        commit();

        // Scoreboard alloc then writeback
        applyStimulus(0, 0, 0, 0, 1, 5, 5, 5);
        checkOutput("alloc_same_cycle", {31'h0, Busy1}, 32'h0);
        commit();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
        checkOutput("alloc_busy", {31'h0, Busy1}, 32'h1);
        commit();
        applyStimulus(0, 1, 5, 16'h00A5, 0, 0, 5, 5);
        checkOutput("wb_busy_clear", {31'h0, Busy1}, 32'h0);
        checkOutput("wb_bus", {16'h0, Bus1}, 32'h00A5);
        commit();

        // Collision: set wins
        applyStimulus(0, 1, 2, 16'h0042, 1, 2, 2, 2);
        commit();
        applyStimulus(0, 0, 0, 0, 0, 0, 2, 2);
        checkOutput("coll_data", {16'h0, Bus1}, 32'h0042);
        checkOutput("coll_busy", {31'h0, Busy1}, 32'h1);
        commit();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom),
                          16'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            commit();
        end

        // Wide variant: 32-bit, 16 regs, no zero register, all-ones reset value
        @(negedge clk);
        #2;
        checkOutput("wide_rst_bus", bBus1, 32'h0);
        checkOutput("wide_rst_busy", {31'h0, bBusy1}, 32'h0);
        @(negedge clk);
        bReset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bRs1 = 4'(i); bRs2 = 4'(15 - i);
            #2;
            checkOutput("wide_reset_val1", bBus1, 32'hFFFF_FFFF);
            checkOutput("wide_reset_val2", bBus2, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        bRegWr = 1'b1; bRd = 4'd0; bWBus = 32'h1; bRs1 = 4'd0;
        #2;
        checkOutput("wide_r0_bypass", bBus1, 32'h1);
        @(negedge clk);
        bRegWr = 1'b0; bAlloc = 1'b1; bAllocRd = 4'd0;
        #2;
        checkOutput("wide_r0_read", bBus1, 32'h1);
        @(negedge clk);
        bAlloc = 1'b0;
        #2;
        checkOutput("wide_r0_busy", {31'h0, bBusy1}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
